// File: rtl/rob_ctrl_pkg.sv
// Shared reorder-buffer definitions: default sizes, entry type encodings
// and a helper that recognises control-transfer entries.
package rob_ctrl_pkg;
  localparam int ROB_SIZE_DEFAULT = 16;
  localparam int TAG_W_DEFAULT    = 4;
  localparam int TYPE_W           = 3;
  localparam int REG_W            = 5;
  localparam int DATA_W           = 32;

  typedef enum logic [TYPE_W-1:0] {
    TypeReg      = 3'd0,
    TypeLoad     = 3'd1,
    TypeStore    = 3'd2,
    TypePc       = 3'd3,
    TypePcAndReg = 3'd4
  } rob_type_e;

  localparam logic Valid   = 1'b1;
  localparam logic Invalid = 1'b0;

  // Only these two kinds of entry may redirect fetch when they retire.
  function automatic logic isCtrlType(input logic [TYPE_W-1:0] entryType);
    return (entryType == TypePc) || (entryType == TypePcAndReg);
  endfunction
endpackage

// File: rtl/rob_query_port.sv
// One dispatch operand lookup: returns a stored ROB result when the entry has
// completed, otherwise forwards a matching CDB broadcast from this cycle.
module rob_query_port
  import rob_ctrl_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEFAULT,
  parameter int TAG_W    = TAG_W_DEFAULT
) (
  input  logic [TAG_W-1:0]    i_q_tag,
  input  logic [ROB_SIZE-1:0] i_busy,
  input  logic [ROB_SIZE-1:0] i_ready,
  input  logic [DATA_W-1:0]   i_value [ROB_SIZE],
  input  logic                i_cdb_valid,
  input  logic [TAG_W-1:0]    i_cdb_tag,
  input  logic [DATA_W-1:0]   i_cdb_value,
  output logic                o_ready,
  output logic [DATA_W-1:0]   o_value
);
  always_comb begin
    o_ready = Invalid;
    o_value = '0;
    if (i_busy[i_q_tag] && i_ready[i_q_tag]) begin
      o_ready = Valid;
      o_value = i_value[i_q_tag];
    end else if (i_cdb_valid && (i_cdb_tag == i_q_tag)) begin
      o_ready = Valid;
      o_value = i_cdb_value;
    end
  end
endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer controller: in-order tag allocation, CDB completion,
// single in-order retire per cycle and flush on a redirecting control entry.
module rob_ctrl
  import rob_ctrl_pkg::*;
#(
  parameter int ROB_SIZE = ROB_SIZE_DEFAULT,
  parameter int TAG_W    = TAG_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_rdy,
  input  logic              i_alloc_valid,
  input  logic              i_alloc_ready,
  input  logic [REG_W-1:0]  i_alloc_reg_dest,
  input  logic [TYPE_W-1:0] i_alloc_type,
  output logic [TAG_W-1:0]  o_alloc_tag,
  output logic              o_is_full,
  input  logic              i_cdb_valid,
  input  logic [TAG_W-1:0]  i_cdb_tag,
  input  logic [DATA_W-1:0] i_cdb_value,
  input  logic              i_cdb_jump,
  input  logic [DATA_W-1:0] i_cdb_target_pc,
  input  logic [TAG_W-1:0]  i_q1_tag,
  input  logic [TAG_W-1:0]  i_q2_tag,
  output logic              o_q1_ready,
  output logic              o_q2_ready,
  output logic [DATA_W-1:0] o_q1_value,
  output logic [DATA_W-1:0] o_q2_value,
  output logic              o_commit_valid,
  output logic [TAG_W-1:0]  o_commit_tag,
  output logic [REG_W-1:0]  o_commit_reg_dest,
  output logic [DATA_W-1:0] o_commit_value,
  output logic [TYPE_W-1:0] o_commit_type,
  output logic              o_flush,
  output logic [DATA_W-1:0] o_flush_pc
);
  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(ROB_SIZE);

  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_ready;
  logic [ROB_SIZE-1:0] r_jump;
  logic [TYPE_W-1:0]   r_type     [ROB_SIZE];
  logic [REG_W-1:0]    r_regDest  [ROB_SIZE];
  logic [DATA_W-1:0]   r_value    [ROB_SIZE];
  logic [DATA_W-1:0]   r_target   [ROB_SIZE];
  logic [TAG_W-1:0]    r_head;
  logic [TAG_W-1:0]    r_tail;
  logic [TAG_W:0]      r_count;

  logic w_isFull;
  logic w_commitFire;
  logic w_flushCond;
  logic w_allocFire;
  logic w_cdbFire;

  // A flushing retire squashes everything younger, including this cycle's
  // allocation and completion, so both are gated by the flush condition.
  assign w_isFull     = (r_count == FULL_COUNT);
  assign w_commitFire = i_rdy && r_busy[r_head] && r_ready[r_head];
  assign w_flushCond  = w_commitFire && r_jump[r_head] && isCtrlType(r_type[r_head]);
  assign w_allocFire  = i_rdy && i_alloc_valid && !w_isFull && !w_flushCond;
  assign w_cdbFire    = i_rdy && i_cdb_valid && r_busy[i_cdb_tag] && !w_flushCond;

  assign o_alloc_tag = r_tail;
  assign o_is_full   = w_isFull;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= '0;
      r_ready <= '0;
      r_jump  <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_type[i]    <= '0;
        r_regDest[i] <= '0;
        r_value[i]   <= '0;
        r_target[i]  <= '0;
      end
      r_head            <= '0;
      r_tail            <= '0;
      r_count           <= '0;
      o_commit_valid    <= Invalid;
      o_commit_tag      <= '0;
      o_commit_reg_dest <= '0;
      o_commit_value    <= '0;
      o_commit_type     <= '0;
      o_flush           <= Invalid;
      o_flush_pc        <= '0;
    end else begin
      o_commit_valid <= Invalid;
      o_flush        <= Invalid;

      if (w_cdbFire) begin
        r_ready[i_cdb_tag]  <= Valid;
        r_value[i_cdb_tag]  <= i_cdb_value;
        r_jump[i_cdb_tag]   <= i_cdb_jump;
        r_target[i_cdb_tag] <= i_cdb_target_pc;
      end

      if (w_allocFire) begin
        r_busy[r_tail]    <= Valid;
        r_ready[r_tail]   <= i_alloc_ready;
        r_type[r_tail]    <= i_alloc_type;
        r_regDest[r_tail] <= i_alloc_reg_dest;
        r_value[r_tail]   <= '0;
        r_jump[r_tail]    <= Invalid;
        r_tail            <= r_tail + 1'b1;
      end

      if (w_commitFire) begin
        o_commit_valid    <= Valid;
        o_commit_tag      <= r_head;
        o_commit_reg_dest <= r_regDest[r_head];
        o_commit_value    <= r_value[r_head];
        o_commit_type     <= r_type[r_head];
        r_busy[r_head]    <= Invalid;
        r_head            <= r_head + 1'b1;
      end

      // The flush branch comes last so it overrides the pointer and busy updates above.
      if (w_flushCond) begin
        o_flush    <= Valid;
        o_flush_pc <= r_target[r_head];
        r_busy     <= '0;
        r_head     <= '0;
        r_tail     <= '0;
        r_count    <= '0;
      end else if (w_allocFire && !w_commitFire) begin
        r_count <= r_count + 1'b1;
      end else if (!w_allocFire && w_commitFire) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  rob_query_port #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) u_query1 (
    .i_q_tag     (i_q1_tag),
    .i_busy      (r_busy),
    .i_ready     (r_ready),
    .i_value     (r_value),
    .i_cdb_valid (i_cdb_valid),
    .i_cdb_tag   (i_cdb_tag),
    .i_cdb_value (i_cdb_value),
    .o_ready     (o_q1_ready),
    .o_value     (o_q1_value)
  );

  rob_query_port #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) u_query2 (
    .i_q_tag     (i_q2_tag),
    .i_busy      (r_busy),
    .i_ready     (r_ready),
    .i_value     (r_value),
    .i_cdb_valid (i_cdb_valid),
    .i_cdb_tag   (i_cdb_tag),
    .i_cdb_value (i_cdb_value),
    .o_ready     (o_q2_ready),
    .o_value     (o_q2_value)
  );
endmodule

// File: tb/tb_rob_ctrl.sv
// Self-checking bench for rob_ctrl: directed vector table, hand-written corner
// sequences and randomized traffic against a queue-based ROB model.
module tb_rob_ctrl;
  import rob_ctrl_pkg::*;

  localparam int ROB = 16;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        allocValid;
  logic        allocReady;
  logic [4:0]  allocRegDest;
  logic [2:0]  allocType;
  logic [3:0]  allocTag;
  logic        isFull;
  logic        cdbValid;
  logic [3:0]  cdbTag;
  logic [31:0] cdbValue;
  logic        cdbJump;
  logic [31:0] cdbTargetPc;
  logic [3:0]  q1Tag;
  logic [3:0]  q2Tag;
  logic        q1Ready;
  logic        q2Ready;
  logic [31:0] q1Value;
  logic [31:0] q2Value;
  logic        commitValid;
  logic [3:0]  commitTag;
  logic [4:0]  commitRegDest;
  logic [31:0] commitValue;
  logic [2:0]  commitType;
  logic        flush;
  logic [31:0] flushPc;

  rob_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .i_rdy             (rdy),
    .i_alloc_valid     (allocValid),
    .i_alloc_ready     (allocReady),
    .i_alloc_reg_dest  (allocRegDest),
    .i_alloc_type      (allocType),
    .o_alloc_tag       (allocTag),
    .o_is_full         (isFull),
    .i_cdb_valid       (cdbValid),
    .i_cdb_tag         (cdbTag),
    .i_cdb_value       (cdbValue),
    .i_cdb_jump        (cdbJump),
    .i_cdb_target_pc   (cdbTargetPc),
    .i_q1_tag          (q1Tag),
    .i_q2_tag          (q2Tag),
    .o_q1_ready        (q1Ready),
    .o_q2_ready        (q2Ready),
    .o_q1_value        (q1Value),
    .o_q2_value        (q2Value),
    .o_commit_valid    (commitValid),
    .o_commit_tag      (commitTag),
    .o_commit_reg_dest (commitRegDest),
    .o_commit_value    (commitValue),
    .o_commit_type     (commitType),
    .o_flush           (flush),
    .o_flush_pc        (flushPc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        av;
    logic        ar;
    logic [4:0]  rd;
    logic [2:0]  ty;
    logic        cv;
    logic [3:0]  ct;
    logic [31:0] cval;
    logic        cj;
    logic [31:0] ctgt;
    logic [3:0]  q1;
    logic [3:0]  q2;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [3:0]  eAllocTag;
    logic        eQ1Ready;
    logic [31:0] eQ1Value;
    logic        eCv;
    logic [3:0]  eCtag;
    logic [4:0]  eCrd;
    logic [31:0] eCval;
  } vec_t;

  // The model treats the ROB as an ordered list of in-flight instructions.
  typedef struct {
    logic [3:0]  tag;
    logic        done;
    logic [2:0]  ty;
    logic [4:0]  rd;
    logic [31:0] val;
    logic        jmp;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  int          mTail;
  logic        eCv;
  logic [3:0]  eTag;
  logic [4:0]  eRd;
  logic [31:0] eVal;
  logic [2:0]  eTy;
  logic        eFl;
  logic [31:0] eFpc;

  int checkCount;
  int errCount;

  vec_t tbl[9];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errCount++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    rdy          = s.rdy;
    allocValid   = s.av;
    allocReady   = s.ar;
    allocRegDest = s.rd;
    allocType    = s.ty;
    cdbValid     = s.cv;
    cdbTag       = s.ct;
    cdbValue     = s.cval;
    cdbJump      = s.cj;
    cdbTargetPc  = s.ctgt;
    q1Tag        = s.q1;
    q2Tag        = s.q2;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rdy: 1'b1, av: 1'b0, ar: 1'b0, rd: 5'd0, ty: 3'(TypeReg), cv: 1'b0, ct: 4'd0,
          cval: 32'd0, cj: 1'b0, ctgt: 32'd0, q1: 4'd0, q2: 4'd0};
    return s;
  endfunction

  function automatic vec_t mkRow(input logic av, input logic [4:0] rd, input logic cv,
                                 input logic [3:0] ct, input logic [31:0] cval, input logic [3:0] q1,
                                 input logic [3:0] eAt, input logic eQr, input logic [31:0] eQv,
                                 input logic eC, input logic [3:0] eCt, input logic [4:0] eCr,
                                 input logic [31:0] eCvl);
    vec_t v;
    v.s      = idle();
    v.s.av   = av;
    v.s.rd   = rd;
    v.s.cv   = cv;
    v.s.ct   = ct;
    v.s.cval = cval;
    v.s.q1   = q1;
    v.eAllocTag = eAt;
    v.eQ1Ready  = eQr;
    v.eQ1Value  = eQv;
    v.eCv       = eC;
    v.eCtag     = eCt;
    v.eCrd      = eCr;
    v.eCval     = eCvl;
    return v;
  endfunction

  task automatic queryExpect(input logic [3:0] qt, output logic r, output logic [31:0] v);
    r = 1'b0;
    v = 32'd0;
    foreach (mq[i]) begin
      if (mq[i].tag == qt && mq[i].done) begin
        r = 1'b1;
        v = mq[i].val;
      end
    end
    if (!r && cdbValid && cdbTag == qt) begin
      r = 1'b1;
      v = cdbValue;
    end
  endtask

  // Called at the falling edge: checks combinational outputs, then advances the model.
  task automatic modelPre();
    logic        r;
    logic [31:0] v;
    logic        doCommit;
    logic        doFlush;
    ent_t        h;
    ent_t        n;
    checkOutput("alloc_tag", 32'(allocTag), 32'(mTail));
    checkOutput("is_full", 32'(isFull), 32'(mq.size() == ROB));
    queryExpect(q1Tag, r, v);
    checkOutput("q1_ready", 32'(q1Ready), 32'(r));
    checkOutput("q1_value", q1Value, v);
    queryExpect(q2Tag, r, v);
    checkOutput("q2_ready", 32'(q2Ready), 32'(r));
    checkOutput("q2_value", q2Value, v);

    eCv = 1'b0;
    eFl = 1'b0;
    if (rdy) begin
      doCommit = (mq.size() > 0) && mq[0].done;
      doFlush  = 1'b0;
      if (doCommit) begin
        h = mq[0];
        doFlush = h.jmp && (h.ty == TypePc || h.ty == TypePcAndReg);
        eCv  = 1'b1;
        eTag = h.tag;
        eRd  = h.rd;
        eVal = h.val;
        eTy  = h.ty;
      end
      if (cdbValid && !doFlush) begin
        foreach (mq[i]) begin
          if (mq[i].tag == cdbTag) begin
            mq[i].done = 1'b1;
            mq[i].val  = cdbValue;
            mq[i].jmp  = cdbJump;
            mq[i].tgt  = cdbTargetPc;
          end
        end
      end
      if (allocValid && mq.size() < ROB && !doFlush) begin
        n = '{tag: 4'(mTail), done: allocReady, ty: allocType, rd: allocRegDest,
              val: 32'd0, jmp: 1'b0, tgt: 32'd0};
        mq.push_back(n);
        mTail = (mTail + 1) % ROB;
      end
      if (doCommit) void'(mq.pop_front());
      if (doFlush) begin
        eFl  = 1'b1;
        eFpc = h.tgt;
        mq.delete();
        mTail = 0;
      end
    end
  endtask

  task automatic modelPost();
    checkOutput("commit_valid", 32'(commitValid), 32'(eCv));
    if (eCv) begin
      checkOutput("commit_tag", 32'(commitTag), 32'(eTag));
      checkOutput("commit_reg_dest", 32'(commitRegDest), 32'(eRd));
      checkOutput("commit_value", commitValue, eVal);
      checkOutput("commit_type", 32'(commitType), 32'(eTy));
    end
    checkOutput("flush", 32'(flush), 32'(eFl));
    if (eFl) checkOutput("flush_pc", flushPc, eFpc);
  endtask

  task automatic cycle();
    @(negedge clk);
    modelPre();
    @(posedge clk);
    #1;
    modelPost();
  endtask

  task automatic doReset();
    applyStimulus(idle());
    rst = 1'b1;
    #2;
    checkOutput("reset commit_valid", 32'(commitValid), 32'd0);
    checkOutput("reset flush", 32'(flush), 32'd0);
    checkOutput("reset commit_tag", 32'(commitTag), 32'd0);
    checkOutput("reset flush_pc", flushPc, 32'd0);
    checkOutput("reset alloc_tag", 32'(allocTag), 32'd0);
    checkOutput("reset is_full", 32'(isFull), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    mTail = 0;
  endtask

  task automatic randomStim();
    stim_t s;
    int    pick;
    s = idle();
    s.rdy  = ($urandom_range(0, 9) != 0);
    s.av   = ($urandom_range(0, 9) < 6);
    s.ar   = ($urandom_range(0, 3) == 0);
    s.rd   = 5'($urandom);
    pick   = $urandom_range(0, 9);
    s.ty   = (pick < 5) ? 3'(TypeReg) : (pick < 7) ? 3'(TypeLoad) : (pick < 8) ? 3'(TypeStore) :
             (pick < 9) ? 3'(TypePc) : 3'(TypePcAndReg);
    s.cv   = ($urandom_range(0, 9) < 6);
    s.ct   = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[$urandom_range(0, mq.size() - 1)].tag
                                                           : 4'($urandom);
    s.cval = $urandom;
    s.cj   = ($urandom_range(0, 6) == 0);
    s.ctgt = $urandom;
    s.q1   = ($urandom_range(0, 3) == 0) ? s.ct : 4'($urandom);
    s.q2   = 4'($urandom);
    applyStimulus(s);
  endtask

  initial begin
    stim_t s;
    checkCount = 0;
    errCount   = 0;
    mTail      = 0;
    rst        = 1'b1;
    applyStimulus(idle());
    @(posedge clk);
    #1;

    // Directed table: allocation, out-of-order completion, in-order retire, forwarding.
    doReset();
    tbl[0] = mkRow(1, 5, 0, 0, 32'h0,    0, 0, 0, 32'h0,    0, 0, 0, 32'h0);
    tbl[1] = mkRow(1, 6, 0, 0, 32'h0,    0, 1, 0, 32'h0,    0, 0, 0, 32'h0);
    tbl[2] = mkRow(1, 7, 0, 0, 32'h0,    0, 2, 0, 32'h0,    0, 0, 0, 32'h0);
    tbl[3] = mkRow(0, 0, 1, 1, 32'h22,   1, 3, 1, 32'h22,   0, 0, 0, 32'h0);
    tbl[4] = mkRow(0, 0, 1, 0, 32'h11,   1, 3, 1, 32'h22,   0, 0, 0, 32'h0);
    tbl[5] = mkRow(0, 0, 0, 0, 32'h0,    0, 3, 1, 32'h11,   1, 0, 5, 32'h11);
    tbl[6] = mkRow(0, 0, 0, 0, 32'h0,    2, 3, 0, 32'h0,    1, 1, 6, 32'h22);
    tbl[7] = mkRow(0, 0, 1, 3, 32'hABCD, 3, 3, 1, 32'hABCD, 0, 0, 0, 32'h0);
    tbl[8] = mkRow(0, 0, 0, 0, 32'h0,    2, 3, 0, 32'h0,    0, 0, 0, 32'h0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].s);
      @(negedge clk);
      checkOutput($sformatf("tbl%0d alloc_tag", i), 32'(allocTag), 32'(tbl[i].eAllocTag));
      checkOutput($sformatf("tbl%0d q1_ready", i), 32'(q1Ready), 32'(tbl[i].eQ1Ready));
      checkOutput($sformatf("tbl%0d q1_value", i), q1Value, tbl[i].eQ1Value);
      modelPre();
      @(posedge clk);
      #1;
      modelPost();
      checkOutput($sformatf("tbl%0d commit_valid", i), 32'(commitValid), 32'(tbl[i].eCv));
      if (tbl[i].eCv) begin
        checkOutput($sformatf("tbl%0d commit_tag", i), 32'(commitTag), 32'(tbl[i].eCtag));
        checkOutput($sformatf("tbl%0d commit_rd", i), 32'(commitRegDest), 32'(tbl[i].eCrd));
        checkOutput($sformatf("tbl%0d commit_value", i), commitValue, tbl[i].eCval);
      end
    end

    // Fill to capacity, show allocation is refused, then retire one and wrap.
    doReset();
    for (int i = 0; i < ROB; i++) begin
      s = idle(); s.av = 1'b1; s.rd = 5'(i + 1);
      applyStimulus(s);
      cycle();
    end
    checkOutput("fill is_full", 32'(isFull), 32'd1);
    checkOutput("fill alloc_tag", 32'(allocTag), 32'd0);
    s = idle(); s.av = 1'b1; s.rd = 5'd30;
    applyStimulus(s);
    cycle();
    checkOutput("full blocked alloc_tag", 32'(allocTag), 32'd0);
    checkOutput("full still is_full", 32'(isFull), 32'd1);
    s = idle(); s.av = 1'b1; s.cv = 1'b1; s.ct = 4'd0; s.cval = 32'h77;
    applyStimulus(s);
    cycle();
    s = idle(); s.av = 1'b1; s.rd = 5'd31;
    applyStimulus(s);
    cycle();
    checkOutput("full retire commit_valid", 32'(commitValid), 32'd1);
    checkOutput("full retire is_full", 32'(isFull), 32'd0);
    checkOutput("full retire alloc_tag", 32'(allocTag), 32'd0);
    applyStimulus(s);
    cycle();
    checkOutput("wrap alloc_tag", 32'(allocTag), 32'd1);
    checkOutput("wrap is_full", 32'(isFull), 32'd1);

    // Redirecting control entry retires with a younger allocation and CDB pending.
    doReset();
    s = idle(); s.av = 1'b1; s.ar = 1'b1; s.rd = 5'd1;
    applyStimulus(s); cycle();
    s = idle(); s.av = 1'b1; s.ty = 3'(TypePc);
    applyStimulus(s); cycle();
    s = idle(); s.av = 1'b1; s.rd = 5'd3;
    applyStimulus(s); cycle();
    s = idle(); s.cv = 1'b1; s.ct = 4'd1; s.cval = 32'h44; s.cj = 1'b1; s.ctgt = 32'h1000;
    applyStimulus(s); cycle();
    s = idle(); s.av = 1'b1; s.rd = 5'd9; s.cv = 1'b1; s.ct = 4'd2; s.cval = 32'h55;
    applyStimulus(s); cycle();
    checkOutput("flush commit_valid", 32'(commitValid), 32'd1);
    checkOutput("flush commit_tag", 32'(commitTag), 32'd1);
    checkOutput("flush pulse", 32'(flush), 32'd1);
    checkOutput("flush target", flushPc, 32'h1000);
    checkOutput("flush alloc_tag", 32'(allocTag), 32'd0);
    s = idle(); s.q1 = 4'd2; s.q2 = 4'd3;
    applyStimulus(s);
    @(negedge clk);
    checkOutput("after flush q1_ready", 32'(q1Ready), 32'd0);
    modelPre();
    @(posedge clk); #1;
    modelPost();
    checkOutput("flush one-cycle", 32'(flush), 32'd0);

    // Global enable low freezes a ready head; retire happens on the first enabled edge.
    doReset();
    s = idle(); s.av = 1'b1; s.ar = 1'b1; s.rd = 5'd9;
    applyStimulus(s); cycle();
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.rdy = 1'b0; s.av = 1'b1; s.rd = 5'd10;
      applyStimulus(s); cycle();
      checkOutput($sformatf("stall%0d commit_valid", i), 32'(commitValid), 32'd0);
      checkOutput($sformatf("stall%0d alloc_tag", i), 32'(allocTag), 32'd1);
    end
    applyStimulus(idle()); cycle();
    checkOutput("unstall commit_valid", 32'(commitValid), 32'd1);
    checkOutput("unstall commit_tag", 32'(commitTag), 32'd0);
    checkOutput("unstall commit_rd", 32'(commitRegDest), 32'd9);

    // Randomized traffic against the model.
    doReset();
    for (int i = 0; i < 800; i++) begin
      randomStim();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end
endmodule
